// File: rtl/frame_strobe_writer_if.sv
// Configuration word stream into a column frame writer.
// The master drives data/valid and the slave returns ready.
interface frame_strobe_writer_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_strobe_writer.sv
// Column configuration frame writer: parses header + row words from a stream,
// fills FrameData row by row and then fires one registered one-hot FrameStrobe.
module frame_strobe_writer #(
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumberOfRows    = 16,
  parameter logic [7:0]  ColumnIndex     = 8'd0
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  frame_strobe_writer_if.slave                    cfg,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic                                    err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SKIP   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [7:0] LastRow  = 8'(NumberOfRows - 1);
  localparam logic [7:0] SyncWord = 8'hFA;

  state_t                       state_reg, state_next;
  logic [7:0]                   row_cnt_reg, row_cnt_next;
  logic [7:0]                   frame_idx_reg, frame_idx_next;
  logic                         ready_reg, ready_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         err_reg, err_next;
  logic [MaxFramesPerCol-1:0]   strobe_reg, strobe_next;
  logic                         row_we;
  logic                         fire;
  logic [7:0]                   hdr_sync, hdr_col, hdr_idx;
  logic                         idx_in_range;

  assign fire          = cfg.cfg_valid & ready_reg;
  assign cfg.cfg_ready = ready_reg;
  assign hdr_sync      = cfg.cfg_data[31:24];
  assign hdr_col       = cfg.cfg_data[23:16];
  assign hdr_idx       = cfg.cfg_data[15:8];
  assign idx_in_range  = ({1'b0, hdr_idx} < 9'(MaxFramesPerCol));

  // State register plus all registered outputs
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      row_cnt_reg   <= '0;
      frame_idx_reg <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      strobe_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      row_cnt_reg   <= row_cnt_next;
      frame_idx_reg <= frame_idx_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      strobe_reg    <= strobe_next;
    end
  end

  // Next-state logic; only IDLE interprets a word as a header
  always_comb begin
    state_next     = state_reg;
    row_cnt_next   = row_cnt_reg;
    frame_idx_next = frame_idx_reg;
    err_next       = 1'b0;
    row_we         = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (fire) begin
          row_cnt_next = '0;
          if (hdr_sync != SyncWord) begin
            err_next = 1'b1;
          end else if (hdr_col != ColumnIndex) begin
            state_next = SKIP;
          end else if (!idx_in_range) begin
            err_next   = 1'b1;
            state_next = SKIP;
          end else begin
            frame_idx_next = hdr_idx;
            state_next     = LOAD;
          end
        end
      end
      LOAD, SKIP: begin
        if (fire) begin
          row_we = (state_reg == LOAD);
          if (row_cnt_reg == LastRow) begin
            state_next = (state_reg == LOAD) ? SETUP : IDLE;
          end else begin
            row_cnt_next = row_cnt_reg + 8'd1;
          end
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
    ready_next  = (state_next == IDLE) || (state_next == LOAD) || (state_next == SKIP);
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == HOLD);
    strobe_next = '0;
    if (state_next == STROBE) begin
      strobe_next = MaxFramesPerCol'(1) << frame_idx_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NumberOfRows; gi++) begin : g_row
      logic [FrameBitsPerRow-1:0] row_reg;

      always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
          row_reg <= '0;
        end else if (row_we && (row_cnt_reg == 8'(gi))) begin
          row_reg <= FrameBitsPerRow'(cfg.cfg_data);
        end
      end

      assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_reg;
    end
  endgenerate

  assign FrameStrobe = strobe_reg;
  assign busy        = busy_reg;
  assign frame_done  = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Directed bench for frame_strobe_writer: ColumnIndex=3, four rows, twenty frames.
module tb_frame_strobe_writer;
  localparam int         MF  = 20;
  localparam int         NR  = 4;
  localparam int         DW  = 32 * NR;
  localparam logic [7:0] COL = 8'd3;

  logic          UserCLK = 1'b0;
  logic          resetn  = 1'b0;
  logic [DW-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          busy, frame_done, err;

  frame_strobe_writer_if cfg_if();

  frame_strobe_writer #(
    .MaxFramesPerCol (MF),
    .FrameBitsPerRow (32),
    .NumberOfRows    (NR),
    .ColumnIndex     (COL)
  ) dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .cfg         (cfg_if),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .frame_done  (frame_done),
    .err         (err)
  );

  always #5 UserCLK = ~UserCLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobe_cycles = 0;
  int done_cycles = 0;
  int err_cycles = 0;
  int bad_onehot = 0;
  int strobe_data_change = 0;
  logic [MF-1:0] last_strobe = '0;
  logic [DW-1:0] prev_data = '0;

  localparam logic [DW-1:0] D1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [DW-1:0] DJ = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
  localparam logic [DW-1:0] D2 = {32'h0A0A0A0A, 32'hB0B0B0B0, 32'h0C0C0C0C, 32'hD0D0D0D0};
  localparam logic [DW-1:0] D3 = {32'h12345678, 32'hFA030500, 32'h9ABCDEF0, 32'hFA070200};
  localparam logic [DW-1:0] D4 = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [DW-1:0] D5 = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000001};
  localparam logic [DW-1:0] D6 = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  localparam logic [DW-1:0] D7 = {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001};
  localparam logic [DW-1:0] D8 = {32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'hC3C3C3C3};

  // Observer sampled on the falling edge, away from the active edge
  always @(negedge UserCLK) begin
    if (FrameStrobe != '0) begin
      strobe_cycles++;
      last_strobe = FrameStrobe;
      if (!$onehot(FrameStrobe)) bad_onehot++;
      if (FrameData !== prev_data) strobe_data_change++;
    end
    if (frame_done) done_cycles++;
    if (err) err_cycles++;
    prev_data = FrameData;
  end

  task automatic idle(input int n);
    cfg_if.cfg_valid = 1'b0;
    repeat (n) @(negedge UserCLK);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance
  task automatic send(input logic [31:0] w);
    int t;
    cfg_if.cfg_data  = w;
    cfg_if.cfg_valid = 1'b1;
    t = 0;
    while (cfg_if.cfg_ready !== 1'b1 && t < 50) begin
      @(negedge UserCLK);
      t++;
    end
    if (t >= 50) begin
      total_cnt++;
      $display("FAIL send_timeout: word %h not accepted, cfg_ready=%b required 1", w, cfg_if.cfg_ready);
    end else begin
      @(posedge UserCLK);
      @(negedge UserCLK);
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [DW-1:0] d);
    send(hdr);
    for (int i = 0; i < NR; i++) send(d[32*i +: 32]);
    cfg_if.cfg_valid = 1'b0;
    $display("frame hdr=%h data=%h sent", hdr, d);
  endtask

  task automatic test_reset();
    cfg_if.cfg_data  = 32'hFA030500;
    cfg_if.cfg_valid = 1'b1;
    resetn = 1'b0;
    repeat (3) @(negedge UserCLK);
    total_cnt++;
    if ({FrameData, FrameStrobe, busy, frame_done, err, cfg_if.cfg_ready} !== '0)
      $display("FAIL reset_outputs: data=%h strobe=%h busy=%b done=%b err=%b ready=%b required all 0",
               FrameData, FrameStrobe, busy, frame_done, err, cfg_if.cfg_ready);
    else pass_cnt++;
    cfg_if.cfg_valid = 1'b0;
    resetn = 1'b1;
    @(negedge UserCLK);
    total_cnt++;
    if (cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: ready=%b busy=%b required ready=1 busy=0", cfg_if.cfg_ready, busy);
    else pass_cnt++;
    $display("reset released");
  endtask

  task automatic test_good_frame();
    int s0;
    s0 = strobe_cycles;
    send(32'hFA030500);
    for (int i = 0; i < NR; i++) send(D1[32*i +: 32]);
    cfg_if.cfg_valid = 1'b0;
    $display("frame hdr=fa030500 data=%h sent", D1);
    total_cnt++;
    if (FrameStrobe !== '0 || cfg_if.cfg_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL good_setup: strobe=%h ready=%b busy=%b required 0/0/1", FrameStrobe, cfg_if.cfg_ready, busy);
    else pass_cnt++;
    @(negedge UserCLK);
    total_cnt++;
    if (FrameStrobe !== 20'h00020 || FrameData !== D1)
      $display("FAIL good_strobe: strobe=%h data=%h required strobe=00020 data=%h", FrameStrobe, FrameData, D1);
    else pass_cnt++;
    @(negedge UserCLK);
    total_cnt++;
    if (FrameStrobe !== '0 || frame_done !== 1'b1 || cfg_if.cfg_ready !== 1'b0)
      $display("FAIL good_hold: strobe=%h done=%b ready=%b required 0/1/0", FrameStrobe, frame_done, cfg_if.cfg_ready);
    else pass_cnt++;
    @(negedge UserCLK);
    total_cnt++;
    if (cfg_if.cfg_ready !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL good_idle: ready=%b done=%b busy=%b required 1/0/0", cfg_if.cfg_ready, frame_done, busy);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (strobe_cycles !== s0 + 1)
      $display("FAIL good_strobe_count: strobe cycles=%0d required %0d", strobe_cycles - s0, 1);
    else pass_cnt++;
  endtask

  task automatic test_col_mismatch();
    int s0, e0;
    s0 = strobe_cycles;
    e0 = err_cycles;
    send_frame(32'hFA070200, DJ);
    idle(4);
    #1;
    total_cnt++;
    if (strobe_cycles !== s0 || err_cycles !== e0 || FrameData !== D1 || busy !== 1'b0)
      $display("FAIL col_skip: strobes=%0d errs=%0d data=%h busy=%b required 0/0/%h/0",
               strobe_cycles - s0, err_cycles - e0, FrameData, busy, D1);
    else pass_cnt++;
    send_frame(32'hFA030700, D2);
    idle(4);
    #1;
    total_cnt++;
    if (FrameData !== D2 || last_strobe !== 20'h00080 || strobe_cycles !== s0 + 1)
      $display("FAIL col_next_frame: data=%h strobe=%h count=%0d required %h/00080/1",
               FrameData, last_strobe, strobe_cycles - s0, D2);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    int s0;
    send(32'h12030500);
    cfg_if.cfg_valid = 1'b0;
    $display("bad sync header 12030500 sent");
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0)
      $display("FAIL bad_sync_err: err=%b busy=%b required 1/0", err, busy);
    else pass_cnt++;
    @(negedge UserCLK);
    total_cnt++;
    if (err !== 1'b0)
      $display("FAIL bad_sync_pulse: err=%b required 0", err);
    else pass_cnt++;
    send_frame(32'hFA030000, D3);
    idle(4);
    #1;
    total_cnt++;
    if (FrameData !== D3 || last_strobe !== 20'h00001)
      $display("FAIL after_err_frame: data=%h strobe=%h required %h/00001", FrameData, last_strobe, D3);
    else pass_cnt++;
    s0 = strobe_cycles;
    send(32'hFA031400);
    cfg_if.cfg_valid = 1'b0;
    $display("out-of-range header fa031400 sent");
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b1)
      $display("FAIL bad_index_err: err=%b busy=%b required 1/1", err, busy);
    else pass_cnt++;
    for (int i = 0; i < NR; i++) send(D4[32*i +: 32]);
    idle(4);
    #1;
    total_cnt++;
    if (strobe_cycles !== s0 || FrameData !== D3 || busy !== 1'b0)
      $display("FAIL bad_index_skip: strobes=%0d data=%h busy=%b required 0/%h/0",
               strobe_cycles - s0, FrameData, busy, D3);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lows;
    send(32'hFA030200);
    for (int i = 0; i < NR; i++) send(D5[32*i +: 32]);
    cfg_if.cfg_data  = 32'hFA030900;
    cfg_if.cfg_valid = 1'b1;
    lows = 0;
    while (cfg_if.cfg_ready !== 1'b1 && lows < 10) begin
      lows++;
      @(negedge UserCLK);
    end
    $display("frame hdr=fa030200 data=%h sent, ready low %0d cycles", D5, lows);
    total_cnt++;
    if (lows !== 3)
      $display("FAIL b2b_ready_gap: ready low %0d cycles required 3", lows);
    else pass_cnt++;
    total_cnt++;
    if (FrameData !== D5 || last_strobe !== 20'h00004)
      $display("FAIL b2b_first: data=%h strobe=%h required %h/00004", FrameData, last_strobe, D5);
    else pass_cnt++;
    send_frame(32'hFA030900, D6);
    idle(4);
    #1;
    total_cnt++;
    if (FrameData !== D6 || last_strobe !== 20'h00200)
      $display("FAIL b2b_second: data=%h strobe=%h required %h/00200", FrameData, last_strobe, D6);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int gap;
    send(32'hFA030B00);
    for (int i = 0; i < NR; i++) begin
      cfg_if.cfg_valid = 1'b0;
      gap = $urandom_range(1, 3);
      repeat (gap) @(negedge UserCLK);
      total_cnt++;
      if (busy !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || FrameStrobe !== '0)
        $display("FAIL stall_hold_%0d: busy=%b ready=%b strobe=%h required 1/1/0",
                 i, busy, cfg_if.cfg_ready, FrameStrobe);
      else pass_cnt++;
      send(D7[32*i +: 32]);
    end
    cfg_if.cfg_valid = 1'b0;
    $display("frame hdr=fa030b00 data=%h sent with stalls", D7);
    idle(4);
    #1;
    total_cnt++;
    if (FrameData !== D7 || last_strobe !== 20'h00800)
      $display("FAIL stall_frame: data=%h strobe=%h required %h/00800", FrameData, last_strobe, D7);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int s0;
    s0 = strobe_cycles;
    send(32'hFA030D00);
    send(32'hABABABAB);
    send(32'hCDCDCDCD);
    cfg_if.cfg_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    $display("reset asserted mid-load");
    total_cnt++;
    if (FrameData !== '0 || cfg_if.cfg_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_async: data=%h ready=%b busy=%b required 0/0/0", FrameData, cfg_if.cfg_ready, busy);
    else pass_cnt++;
    @(negedge UserCLK);
    resetn = 1'b1;
    idle(4);
    #1;
    total_cnt++;
    if (strobe_cycles !== s0 || FrameData !== '0)
      $display("FAIL midreset_nostrobe: strobes=%0d data=%h required 0/0", strobe_cycles - s0, FrameData);
    else pass_cnt++;
    send_frame(32'hFA031300, D8);
    idle(4);
    #1;
    total_cnt++;
    if (FrameData !== D8 || last_strobe !== 20'h80000)
      $display("FAIL midreset_recover: data=%h strobe=%h required %h/80000", FrameData, last_strobe, D8);
    else pass_cnt++;
  endtask

  task automatic test_invariants();
    #1;
    total_cnt++;
    if (bad_onehot !== 0 || strobe_data_change !== 0)
      $display("FAIL strobe_invariants: non-onehot=%0d data-change-at-strobe=%0d required 0/0",
               bad_onehot, strobe_data_change);
    else pass_cnt++;
    total_cnt++;
    if (done_cycles !== strobe_cycles || strobe_cycles !== 7)
      $display("FAIL strobe_done_count: strobes=%0d dones=%0d required 7/7", strobe_cycles, done_cycles);
    else pass_cnt++;
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    @(negedge UserCLK);
    test_reset();
    test_good_frame();
    test_col_mismatch();
    test_errors();
    test_back_to_back();
    test_stall();
    test_reset_mid_load();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_strobe_writer.md
# frame_strobe_writer

Configuration frame writer for one fabric column: accepts a stream of 32-bit configuration words and drives that column's `FrameData` and one-hot `FrameStrobe` buses. Each frame is a header followed by one data word per row. The block sits at the bottom of each column's strobe chain and feeds the tiles' `FrameStrobe` inputs; the terminal tiles forward these unchanged through their strobe buffers.

## Interface
- `MaxFramesPerCol`, default 20: width of `FrameStrobe`; valid frame indices are 0..MaxFramesPerCol-1.
- `FrameBitsPerRow`, default 32: bits per row per frame; must equal 32, the configuration word width.
- `NumberOfRows`, default 16: data words per frame, in the range 1..255.
- `ColumnIndex`, default 0: the column address this instance responds to, 8 bits.

Ports (clock and reset first):
- `UserCLK`  in  1  the single clock; all state changes on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `cfg_data`  in  32  configuration word.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  the block accepts a word in a cycle where `cfg_valid` and `cfg_ready` are both high.
- `FrameData`  out  FrameBitsPerRow*NumberOfRows  frame data; row r occupies bits [32r+31:32r].
- `FrameStrobe`  out  MaxFramesPerCol  one-hot, single-cycle write strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame write completes.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- **Header word fields:** [31:24] sync, which must equal 8'hFA; [23:16] column; [15:8] frame index; [7:0] reserved and ignored.
- **States:** IDLE, LOAD, SKIP, SETUP, STROBE, HOLD.
- **IDLE:** `cfg_ready`=1. On header acceptance:
  - sync ≠ FA: `err` pulses next cycle, word is dropped, state stays IDLE.
  - sync ok, column = ColumnIndex and index < MaxFramesPerCol: latch the index, clear the row counter, go to LOAD.
  - sync ok, column ≠ ColumnIndex: go to SKIP, no error.
  - sync ok, column matches but index ≥ MaxFramesPerCol: `err` pulses, go to SKIP.
- **LOAD:** `cfg_ready`=1.
  - Each accepted word is written to row slice `row_cnt` of `FrameData`, then `row_cnt` increments.
  - Rows are filled in order 0 first, NumberOfRows-1 last.
  - After row NumberOfRows-1 is accepted, go to SETUP.
- **SKIP:** `cfg_ready`=1. Accept and discard NumberOfRows words; `FrameData` is unchanged. Then go to IDLE.
- **SETUP:** `cfg_ready`=0, all strobes low, `FrameData` stable. Lasts 1 cycle, then STROBE.
- **STROBE:** `cfg_ready`=0, `FrameStrobe[index]`=1 and all other bits 0. Lasts 1 cycle, then HOLD.
- **HOLD:** `cfg_ready`=0, strobes low, `frame_done`=1. Lasts 1 cycle, then IDLE.
- **Between frames:** `FrameData` holds its value until it is overwritten. It is never cleared except by reset.
- **Counter width:** `row_cnt` is 8 bits. It compares against NumberOfRows-1, so it never wraps.
- **`cfg_valid` low** in LOAD or SKIP stalls the block indefinitely with no timeout; the state and `row_cnt` are held.

## Timing
- **Reset values:** `cfg_ready`=0 while `resetn`=0 and 1 from the first cycle after release. `FrameData`=0, `FrameStrobe`=0, `busy`=0, `frame_done`=0, `err`=0. State = IDLE, `row_cnt`=0.
- **Reset mid-frame:** all outputs go to their reset values asynchronously. The partial frame is discarded and no strobe is issued.
- **Outputs are registered;** there is no combinational path from `cfg_*` to the outputs.
- **Frame timeline:** the last data word is accepted at edge E0.
  - SETUP runs during E0→E1.
  - `FrameStrobe` is high during E1→E2.
  - `frame_done` is high during E2→E3.
  - `cfg_ready` returns high after E3.
  - Minimum frame period is NumberOfRows+4 cycles.
- **`err` timing:** pulses in the cycle after the offending header is accepted.
- **Data word values are unconstrained;** a data word starting with FA is treated as data, never as a header.
- **Single strobe guarantee:** exactly one strobe bit is high for exactly one cycle per accepted frame. It never coincides with a `FrameData` change.

## Test plan
- **Reset:** hold `resetn`=0 while `cfg_valid`=1 -> all outputs 0, no word consumed. Release -> `cfg_ready`=1 next cycle.
- **Good frame:** ColumnIndex=3, NumberOfRows=4; send header 32'hFA030500, then data 11111111, 22222222, 33333333, 44444444 with no gaps.
  - `FrameData` = 44444444_33333333_22222222_11111111.
  - `FrameStrobe` = 1<<5 for one cycle, two cycles after the last word.
  - `frame_done` pulses one cycle later.
  - No other strobe bit ever rises.
- **Column mismatch:** header FA070200 followed by 4 words -> all consumed, `FrameStrobe` stays 0, `FrameData` keeps the previous frame, `err`=0. A following valid frame works.
- **Errors:**
  - Header 12030500 -> `err` pulse, state stays IDLE; the next word FA030000 starts a normal frame.
  - Header FA031400 (index 20) -> `err` pulse, the 4 words are skipped, no strobe.
- **Backpressure and stall:** `cfg_valid` held high throughout -> `cfg_ready` low for exactly 3 cycles after the last data word. `cfg_valid` toggled randomly in LOAD -> correct row order and correct data.
- **Reset mid-LOAD:** after 2 data words, pulse `resetn` low -> `FrameData`=0, no strobe. A new complete frame then writes correctly.
